mmio_timer_periph: RTL and testbench

- Memory-mapped peripheral block on the MEM-stage data bus, in parallel with data RAM.
- Decodes ALU-computed addresses in the 0x4000_0000 window.
- Provides a reloadable interrupt timer (TH/TL/TCON), an LED register, a 7-segment digit register and a free-running SysTick counter.
- Drives the CPU IRQ line consumed by the controller and exception-PC logic.

---
 rtl/mmio_timer_periph.sv | 130 +++++++++++++
 tb/tb_mmio_timer_periph.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer_periph.sv
`default_nettype none
// ============================================================================
//  Module   : mmio_timer_periph
//  Purpose  : MEM-stage memory-mapped peripherals: reloadable interrupt timer,
//             LED and 7-segment digit registers, free-running SysTick counter.
//  Revision : 1.0 - initial release
// ============================================================================
module mmio_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          LED_W     = 8,
    parameter int          DIGI_W    = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Address,
    input  logic [31:0]       Write_data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       Read_data,
    output logic              hit,
    output logic              IRQ,
    output logic [LED_W-1:0]  LED,
    output logic [DIGI_W-1:0] digi
);

    localparam logic [2:0] c_OFF_TH      = 3'd0;
    localparam logic [2:0] c_OFF_TL      = 3'd1;
    localparam logic [2:0] c_OFF_TCON    = 3'd2;
    localparam logic [2:0] c_OFF_LED     = 3'd3;
    localparam logic [2:0] c_OFF_DIGI    = 3'd4;
    localparam logic [2:0] c_OFF_SYSTICK = 3'd5;

    logic [31:0]       r_th;
    logic [31:0]       r_tl;
    logic [2:0]        r_tcon;
    logic [LED_W-1:0]  r_led;
    logic [DIGI_W-1:0] r_digi;
    logic [31:0]       r_systick;

    logic       w_hit;
    logic [2:0] w_off;
    logic       w_we;
    logic       w_wr_th;
    logic       w_wr_tl;
    logic       w_wr_tcon;
    logic       w_wr_led;
    logic       w_wr_digi;
    logic       w_wr_systick;
    logic       w_ovf;
    logic       w_unused;

    assign w_hit        = (Address[31:5] == BASE_ADDR[31:5]);
    assign w_off        = Address[4:2];
    assign w_we         = MemWrite && w_hit;
    assign w_wr_th      = w_we && (w_off == c_OFF_TH);
    assign w_wr_tl      = w_we && (w_off == c_OFF_TL);
    assign w_wr_tcon    = w_we && (w_off == c_OFF_TCON);
    assign w_wr_led     = w_we && (w_off == c_OFF_LED);
    assign w_wr_digi    = w_we && (w_off == c_OFF_DIGI);
    assign w_wr_systick = w_we && (w_off == c_OFF_SYSTICK);
    assign w_unused     = ^Address[1:0];

    // Overflow is judged on the registered enable and count only.
    assign w_ovf = r_tcon[0] && (r_tl == 32'hFFFF_FFFF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_th      <= 32'd0;
            r_tl      <= 32'd0;
            r_tcon    <= 3'd0;
            r_led     <= '0;
            r_digi    <= '0;
            r_systick <= 32'd0;
        end else begin
            if (w_wr_systick) begin
                r_systick <= Write_data;
            end else begin
                r_systick <= r_systick + 32'd1;
            end

            if (w_wr_th) begin
                r_th <= Write_data;
            end

            // A software store to TL beats both reload and increment.
            if (w_wr_tl) begin
                r_tl <= Write_data;
            end else if (r_tcon[0]) begin
                r_tl <= w_ovf ? r_th : (r_tl + 32'd1);
            end

            // A software store to TCON discards a coincident status-set.
            if (w_wr_tcon) begin
                r_tcon <= Write_data[2:0];
            end else if (w_ovf && r_tcon[1]) begin
                r_tcon[2] <= 1'b1;
            end

            if (w_wr_led) begin
                r_led <= Write_data[LED_W-1:0];
            end

            if (w_wr_digi) begin
                r_digi <= Write_data[DIGI_W-1:0];
            end
        end
    end

    always_comb begin
        Read_data = 32'd0;
        if (MemRead && w_hit) begin
            case (w_off)
                c_OFF_TH:      Read_data = r_th;
                c_OFF_TL:      Read_data = r_tl;
                c_OFF_TCON:    Read_data = {29'd0, r_tcon};
                c_OFF_LED:     Read_data = {{(32-LED_W){1'b0}}, r_led};
                c_OFF_DIGI:    Read_data = {{(32-DIGI_W){1'b0}}, r_digi};
                c_OFF_SYSTICK: Read_data = r_systick;
                default:       Read_data = 32'd0;
            endcase
        end
    end

    assign hit  = w_hit;
    assign IRQ  = r_tcon[1] & r_tcon[2];
    assign LED  = r_led;
    assign digi = r_digi;

endmodule
`default_nettype wire

// File: tb/tb_mmio_timer_periph.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mmio_timer_periph
//  Purpose  : Directed self-checking bench for mmio_timer_periph.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mmio_timer_periph;

    localparam logic [31:0] c_A_TH      = 32'h4000_0000;
    localparam logic [31:0] c_A_TL      = 32'h4000_0004;
    localparam logic [31:0] c_A_TCON    = 32'h4000_0008;
    localparam logic [31:0] c_A_LED     = 32'h4000_000C;
    localparam logic [31:0] c_A_DIGI    = 32'h4000_0010;
    localparam logic [31:0] c_A_SYSTICK = 32'h4000_0014;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Read_data;
    logic        hit;
    logic        IRQ;
    logic [7:0]  LED;
    logic [11:0] digi;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    mmio_timer_periph #(
        .BASE_ADDR (32'h4000_0000),
        .LED_W     (8),
        .DIGI_W    (12)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .Address    (Address),
        .Write_data (Write_data),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .Read_data  (Read_data),
        .hit        (hit),
        .IRQ        (IRQ),
        .LED        (LED),
        .digi       (digi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #50000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic compare(input logic [31:0] obs);
        logic [31:0] e;
        string       t;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_underflow observed=%h expected=queued_value", obs);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", t, obs, e);
            end
        end
    endtask

    task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        compare(obs);
    endtask

    // Bus load: expectation is queued as the load is driven, compared 1 unit later.
    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        Address = addr;
        MemRead = 1'b1;
        #1;
        compare(Read_data);
        MemRead = 1'b0;
    endtask

    // Bus store: committed at the next rising edge.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        Address    = addr;
        Write_data = data;
        MemWrite   = 1'b1;
        @(posedge clk);
        #1;
        MemWrite   = 1'b0;
        Write_data = 32'd0;
    endtask

    initial begin
        reset      = 1'b0;
        Address    = 32'd0;
        Write_data = 32'd0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;

        // Power-on reset state
        @(negedge clk);
        rd(c_A_TH,      32'd0, "por_th");
        rd(c_A_TL,      32'd0, "por_tl");
        rd(c_A_TCON,    32'd0, "por_tcon");
        rd(c_A_SYSTICK, 32'd0, "por_systick");
        chk({31'd0, IRQ},  32'd0, "por_irq");
        chk({24'd0, LED},  32'd0, "por_led");
        chk({20'd0, digi}, 32'd0, "por_digi");
        @(negedge clk);
        reset = 1'b1;

        // Reset asserted in the middle of a running count
        wr(c_A_TH,   32'd100);
        wr(c_A_TL,   32'd0);
        wr(c_A_TCON, 32'd1);
        wr(c_A_LED,  32'h3C);
        wr(c_A_DIGI, 32'h123);
        @(negedge clk);
        rd(c_A_TL, 32'd2, "count_before_reset");
        reset = 1'b0;
        rd(c_A_TL,   32'd0, "async_rst_tl");
        rd(c_A_TCON, 32'd0, "async_rst_tcon");
        rd(c_A_TH,   32'd0, "async_rst_th");
        chk({24'd0, LED}, 32'd0, "async_rst_led");
        repeat (3) @(negedge clk);
        rd(c_A_SYSTICK, 32'd0, "held_rst_systick");
        rd(c_A_TL,      32'd0, "held_rst_tl");
        chk({31'd0, IRQ},  32'd0, "held_rst_irq");
        chk({20'd0, digi}, 32'd0, "held_rst_digi");
        @(negedge clk);
        reset = 1'b1;
        rd(c_A_SYSTICK, 32'd0, "release_systick0");
        @(negedge clk);
        rd(c_A_SYSTICK, 32'd1, "release_systick1");

        // Bus decode
        wr(c_A_LED,  32'hA5);
        wr(c_A_DIGI, 32'h3FF);
        @(negedge clk);
        chk({24'd0, LED},  32'hA5,  "led_store");
        chk({20'd0, digi}, 32'h3FF, "digi_store");
        rd(32'h4000_0018, 32'd0, "unmapped_18");
        chk({31'd0, hit}, 32'd1, "hit_window");
        rd(32'h4000_001C, 32'd0, "unmapped_1c");
        rd(32'h1000_000C, 32'd0, "miss_read");
        chk({31'd0, hit}, 32'd0, "hit_miss");
        rd(32'h4000_000F, 32'hA5, "byte_bits_ignored");
        wr(32'h1000_000C, 32'hFF);
        wr(32'h4000_0018, 32'hFFFF_FFFF);
        @(negedge clk);
        chk({24'd0, LED}, 32'hA5, "miss_store_no_effect");
        Address = c_A_LED;
        MemRead = 1'b0;
        #1;
        chk(Read_data, 32'd0, "no_memread_zero");
        Write_data = 32'h5A;
        MemWrite   = 1'b1;
        rd(c_A_LED, 32'hA5, "rw_pre_write_value");
        @(posedge clk);
        #1;
        MemWrite = 1'b0;
        @(negedge clk);
        chk({24'd0, LED}, 32'h5A, "rw_commit");
        wr(c_A_TCON, 32'hFFFF_FFF8);
        @(negedge clk);
        rd(c_A_TCON, 32'd0, "tcon_upper_zero");

        // Timer reload with interrupt
        wr(c_A_TH,   32'hFFFF_FFFC);
        wr(c_A_TL,   32'hFFFF_FFFE);
        wr(c_A_TCON, 32'd3);
        @(negedge clk);
        rd(c_A_TL, 32'hFFFF_FFFE, "arm_tl");
        @(negedge clk);
        rd(c_A_TL, 32'hFFFF_FFFF, "pre_ovf_tl");
        chk({31'd0, IRQ}, 32'd0, "pre_ovf_irq");
        @(negedge clk);
        rd(c_A_TL,   32'hFFFF_FFFC, "reload_tl");
        rd(c_A_TCON, 32'd7,         "reload_tcon");
        chk({31'd0, IRQ}, 32'd1, "reload_irq");
        @(negedge clk);
        rd(c_A_TL, 32'hFFFF_FFFD, "post_reload_tl");

        // Interrupt clear and re-arm
        wr(c_A_TCON, 32'd1);
        @(negedge clk);
        chk({31'd0, IRQ}, 32'd0, "clr_irq");
        rd(c_A_TL,   32'hFFFF_FFFE, "clr_tl_counting");
        rd(c_A_TCON, 32'd1,         "clr_tcon");
        @(negedge clk);
        @(negedge clk);
        rd(c_A_TL,   32'hFFFF_FFFC, "noint_reload_tl");
        rd(c_A_TCON, 32'd1,         "noint_tcon");
        chk({31'd0, IRQ}, 32'd0, "noint_irq");
        wr(c_A_TCON, 32'd3);
        @(negedge clk);
        rd(c_A_TCON, 32'd3, "rearm_tcon");
        chk({31'd0, IRQ}, 32'd0, "rearm_irq0");
        @(negedge clk);
        chk({31'd0, IRQ}, 32'd0, "rearm_irq1");
        @(negedge clk);
        chk({31'd0, IRQ}, 32'd0, "rearm_irq2");
        @(negedge clk);
        chk({31'd0, IRQ}, 32'd1, "rearm_irq_ovf");
        rd(c_A_TCON, 32'd7, "rearm_tcon_ovf");

        // TL store in an overflow cycle
        wr(c_A_TCON, 32'd0);
        wr(c_A_TL,   32'hFFFF_FFFF);
        wr(c_A_TCON, 32'd3);
        wr(c_A_TL,   32'h10);
        @(negedge clk);
        rd(c_A_TL,   32'h10, "coll_tl_wins");
        rd(c_A_TCON, 32'd7,  "coll_tl_status_set");
        chk({31'd0, IRQ}, 32'd1, "coll_tl_irq");

        // TCON store in an overflow cycle
        wr(c_A_TCON, 32'd0);
        wr(c_A_TL,   32'hFFFF_FFFF);
        wr(c_A_TCON, 32'd3);
        wr(c_A_TCON, 32'd1);
        @(negedge clk);
        rd(c_A_TCON, 32'd1,         "coll_tcon_wins");
        rd(c_A_TL,   32'hFFFF_FFFC, "coll_tcon_reload");
        chk({31'd0, IRQ}, 32'd0, "coll_tcon_irq");

        // TH store in an overflow cycle reloads the old TH
        wr(c_A_TCON, 32'd0);
        wr(c_A_TL,   32'hFFFF_FFFF);
        wr(c_A_TCON, 32'd1);
        wr(c_A_TH,   32'h20);
        @(negedge clk);
        rd(c_A_TL, 32'hFFFF_FFFC, "coll_th_old_reload");
        rd(c_A_TH, 32'h20,        "coll_th_new");

        // Disabled timer holds while SysTick runs
        wr(c_A_TCON,    32'd0);
        wr(c_A_TL,      32'd5);
        wr(c_A_SYSTICK, 32'd1000);
        @(negedge clk);
        rd(c_A_TL,      32'd5,    "hold_tl0");
        rd(c_A_SYSTICK, 32'd1000, "systick_load");
        repeat (10) @(negedge clk);
        rd(c_A_TL,      32'd5,    "hold_tl10");
        rd(c_A_SYSTICK, 32'd1010, "systick_plus10");

        // SysTick wrap
        wr(c_A_SYSTICK, 32'hFFFF_FFFF);
        @(negedge clk);
        rd(c_A_SYSTICK, 32'hFFFF_FFFF, "systick_max");
        @(negedge clk);
        rd(c_A_SYSTICK, 32'd0, "systick_wrap");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
